query_enumerator: RTL

QUERY_ENUMERATOR -- requirements
Module: query_enumerator

---
 rtl/qa_prolog_pkg.sv | 15 +
 rtl/query_enumerator_if.sv | 20 ++
 rtl/mult_check.sv | 23 ++
 rtl/query_enumerator.sv | 138 +++++++++++++
 4 files changed

// File: rtl/qa_prolog_pkg.sv
// Shared types and constants for the QA-Prolog query hardware.
//   state_t      : enumerator FSM state encoding
//   DEF_NUM_BITS : default integer operand width
package qa_prolog_pkg;

    localparam int unsigned DEF_NUM_BITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : qa_prolog_pkg

// File: rtl/query_enumerator_if.sv
// Solution output channel of the query enumerator (valid/ready handshake).
//   out_valid : a solution pair is presented (master -> slave)
//   out_ready : consumer accepts the pair        (slave -> master)
//   out_a     : solution operand A               (master -> slave)
//   out_b     : solution operand B               (master -> slave)
interface query_enumerator_if
    import qa_prolog_pkg::*;
#(
    parameter int unsigned NUM_BITS = DEF_NUM_BITS
);

    logic                out_valid;
    logic                out_ready;
    logic [NUM_BITS-1:0] out_a;
    logic [NUM_BITS-1:0] out_b;

    modport master (output out_valid, output out_a, output out_b, input  out_ready);
    modport slave  (input  out_valid, input  out_a, input  out_b, output out_ready);

endinterface : query_enumerator_if

// File: rtl/mult_check.sv
// Combinational match for mult(A,B,C): valid when A*B, truncated to
// NUM_BITS, equals C -- same wrap-around as the generated Query netlist.
//   a, b  : candidate operands
//   c     : target product
//   valid : candidate satisfies the relation
module mult_check
    import qa_prolog_pkg::*;
#(
    parameter int unsigned NUM_BITS = DEF_NUM_BITS
) (
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic [NUM_BITS-1:0] c,
    output logic                valid
);

    // NUM_BITS-wide context drops the high half of the product (mod 2^NUM_BITS)
    logic [NUM_BITS-1:0] prod;

    assign prod  = a * b;
    assign valid = (prod == c);

endmodule : mult_check

// File: rtl/query_enumerator.sv
// Enumerates every (A,B) with A*B mod 2^NUM_BITS == target, one candidate
// per cycle, A-major, and streams solutions over a valid/ready channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a sweep (accepted only in IDLE)
//   abort      : stop a sweep in progress, no done pulse
//   target     : product C, latched on accepted start
//   out_if     : solution channel (out_valid/out_ready/out_a/out_b)
//   busy       : high in SWEEP, HOLD and DONE
//   done       : one-cycle pulse at sweep end
//   sol_count  : solutions emitted in the current or last sweep
module query_enumerator
    import qa_prolog_pkg::*;
#(
    parameter int unsigned NUM_BITS = DEF_NUM_BITS,
    parameter int unsigned CNT_W    = 2*NUM_BITS+1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [NUM_BITS-1:0] target,
    query_enumerator_if.master  out_if,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    sol_count
);

    localparam int unsigned CAND_W = 2*NUM_BITS;

    state_t              state;
    logic [NUM_BITS-1:0] target_q;
    logic [CAND_W-1:0]   cand;       // {A,B}: incrementing walks A-major, B-minor
    logic                exhausted;  // last candidate already evaluated
    logic                match_c;
    logic                stall_c;
    logic                last_c;
    logic [NUM_BITS-1:0] cand_a_c;
    logic [NUM_BITS-1:0] cand_b_c;

    assign cand_a_c = cand[CAND_W-1:NUM_BITS];
    assign cand_b_c = cand[NUM_BITS-1:0];
    assign last_c   = (cand == {CAND_W{1'b1}});
    // presented pair will still be occupying the output after this edge
    assign stall_c  = out_if.out_valid && !out_if.out_ready;

    mult_check #(.NUM_BITS(NUM_BITS)) u_mult_check (
        .a     (cand_a_c),
        .b     (cand_b_c),
        .c     (target_q),
        .valid (match_c)
    );

    // Enumerator FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            target_q         <= '0;
            cand             <= '0;
            exhausted        <= 1'b0;
            out_if.out_valid <= 1'b0;
            out_if.out_a     <= '0;
            out_if.out_b     <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            sol_count        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        target_q  <= target;
                        sol_count <= '0;
                        cand      <= '0;
                        exhausted <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SWEEP;
                    end
                end

                SWEEP: begin
                    if (abort) begin
                        out_if.out_valid <= 1'b0;
                        busy             <= 1'b0;
                        state            <= IDLE;
                    end else if (exhausted) begin
                        // drain the final pair before signalling completion
                        if (!stall_c) begin
                            out_if.out_valid <= 1'b0;
                            done             <= 1'b1;
                            state            <= DONE;
                        end
                    end else if (match_c && stall_c) begin
                        state <= HOLD;
                    end else begin
                        if (match_c) begin
                            out_if.out_a     <= cand_a_c;
                            out_if.out_b     <= cand_b_c;
                            out_if.out_valid <= 1'b1;
                            sol_count        <= sol_count + CNT_W'(1);
                        end else if (out_if.out_ready) begin
                            out_if.out_valid <= 1'b0;
                        end
                        cand      <= cand + CAND_W'(1);
                        exhausted <= last_c;
                    end
                end

                HOLD: begin
                    // candidate frozen; out_valid is high here, so ready is the transfer
                    if (abort) begin
                        out_if.out_valid <= 1'b0;
                        busy             <= 1'b0;
                        state            <= IDLE;
                    end else if (out_if.out_ready) begin
                        out_if.out_a     <= cand_a_c;
                        out_if.out_b     <= cand_b_c;
                        out_if.out_valid <= 1'b1;
                        sol_count        <= sol_count + CNT_W'(1);
                        cand             <= cand + CAND_W'(1);
                        exhausted        <= last_c;
                        state            <= SWEEP;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : query_enumerator
